fft_bitrev_reorder: RTL

- Output-side reorder buffer for the pipelined radix-2 FFT.
- Reads the butterfly chain's result stream, which arrives in bit-reversed index order, one complex sample per cycle.
- Emits the same samples in natural order 0..N-1.
- Ping-pong banks give sustained 1 sample/cycle throughput, with valid/ready flow control on both sides.

---
 rtl/fft_bitrev_reorder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT result stream in, natural-order stream out.
// Define FFT_REORDER_CONJ_EN to negate the imaginary part on output (IFFT by conjugation).
module fft_bitrev_reorder #(
  parameter int WIDTH = 16,
  parameter int LOG2N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic             out_last,
  output logic [LOG2N-1:0] out_idx
);

  localparam int N  = 1 << LOG2N;
  localparam int DW = 2 * WIDTH;
  localparam logic [LOG2N-1:0] IDX_LAST = {LOG2N{1'b1}};

  // Both banks share one array; the bank pointer is the address MSB.
  logic [DW-1:0]    mem_q [2*N];

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] wr_idx_q, wr_idx_d;
  logic [LOG2N-1:0] rd_idx_q, rd_idx_d;
  logic [LOG2N-1:0] wr_addr_rev;

  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [LOG2N-1:0] out_idx_q, out_idx_d;
  logic [WIDTH-1:0] out_re_q, out_re_d;
  logic [WIDTH-1:0] out_im_q, out_im_d;

  logic             wr_en;
  logic             ld_en;
  logic [DW-1:0]    rd_data;
  logic [WIDTH-1:0] im_load;

  genvar gi;
  generate
    for (gi = 0; gi < LOG2N; gi++) begin : gen_bitrev
      assign wr_addr_rev[gi] = wr_idx_q[LOG2N-1-gi];
    end
  endgenerate

  assign in_ready = ~full_q[wr_bank_q];
  assign wr_en    = in_valid & in_ready;
  assign ld_en    = full_q[rd_bank_q] & (~out_valid_q | out_ready);
  assign rd_data  = mem_q[{rd_bank_q, rd_idx_q}];

`ifdef FFT_REORDER_CONJ_EN
  assign im_load = -rd_data[WIDTH-1:0];
`else
  assign im_load = rd_data[WIDTH-1:0];
`endif

  // Write and read never touch the same bank: writes need FREE, reads need FULL.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[{wr_bank_q, wr_addr_rev}] <= {in_re, in_im};
    end
  end

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    if (wr_en) begin
      wr_idx_d = wr_idx_q + 1'b1;
      if (wr_idx_q == IDX_LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    if (ld_en) begin
      rd_idx_d = rd_idx_q + 1'b1;
      if (rd_idx_q == IDX_LAST) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_idx_d   = out_idx_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    if (ld_en) begin
      out_valid_d = 1'b1;
      out_last_d  = (rd_idx_q == IDX_LAST);
      out_idx_d   = rd_idx_q;
      out_re_d    = rd_data[DW-1:WIDTH];
      out_im_d    = im_load;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_idx   = out_idx_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;

endmodule
